mips_lsu: RTL

MIPS_LSU -- requirements
Module: mips_lsu

---
 rtl/mips_lsu.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_lsu.sv
// Big-endian load/store unit between an in-order core and a byte-laned memory.
// Handles alignment checks, lane steering, and load extension for byte, half, word and double accesses.
module mips_lsu #(
  parameter int XLEN    = 32,
  parameter int LANES   = XLEN / 8,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  output logic               resp_valid,
  output logic [XLEN-1:0]    resp_rdata,
  output logic               resp_err,
  output logic [XLEN-1:0]    mem_addr,
  input  logic [8*LANES-1:0] mem_data_out,
  output logic [8*LANES-1:0] mem_data_in,
  output logic               mem_write_en,
  output logic [LANES-1:0]   mem_lane_en
);

  localparam int MW = 8 * LANES;
  localparam int OW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int XB = XLEN / 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [OW-1:0]   off_q, off_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            accept_s, err_s, store_fire_s;
  logic [2:0]      amask_s;
  int              nbytes_s, ld_nb_s, j_s, lane_s;
  logic [OW-1:0]   off_s;
  logic [XLEN-1:0] aligned_s, ld_s;
  logic [MW-1:0]   st_data_s;
  logic [LANES-1:0] st_lane_s;
  logic            sbit_s;

  // Request decode: alignment/size legality and big-endian store lane steering.
  always_comb begin
    nbytes_s = 32'sd1 << req_size;
    case (req_size)
      2'b00:   amask_s = 3'b000;
      2'b01:   amask_s = 3'b001;
      2'b10:   amask_s = 3'b011;
      default: amask_s = 3'b111;
    endcase
    err_s     = ((req_addr[2:0] & amask_s) != 3'b000) || (nbytes_s > LANES);
    off_s     = req_addr[OW-1:0];
    aligned_s = req_addr;
    aligned_s[OW-1:0] = '0;
    accept_s  = req_valid && (state_q == IDLE) && !rst;
    st_lane_s = '0;
    st_data_s = '0;
    j_s       = 0;
    for (int k = 0; k < LANES; k++) begin
      // Lane k receives store byte j counted from the least significant end.
      j_s = int'(off_s) + nbytes_s - 1 - k;
      if (k >= int'(off_s) && j_s >= 0 && j_s < XB) begin
        st_lane_s[LANES-1-k]   = 1'b1;
        st_data_s[MW-1-8*k -: 8] = req_wdata[8*j_s +: 8];
      end
    end
    store_fire_s = accept_s && req_write && !err_s;
  end

  // Load extraction from the returned word, then zero/sign extension.
  always_comb begin
    ld_s    = '0;
    sbit_s  = 1'b0;
    lane_s  = 0;
    ld_nb_s = 32'sd1 << size_q;
    for (int b = 0; b < XB; b++) begin
      lane_s = int'(off_q) + ld_nb_s - 1 - b;
      if (b < ld_nb_s && lane_s >= 0 && lane_s < LANES) begin
        ld_s[8*b +: 8] = mem_data_out[MW-1-8*lane_s -: 8];
      end
    end
    if (ld_nb_s <= XB) begin
      sbit_s = ld_s[8*ld_nb_s-1];
    end else begin
      sbit_s = 1'b0;
    end
    for (int b = 0; b < XB; b++) begin
      if (b >= ld_nb_s) begin
        ld_s[8*b +: 8] = {8{sgn_q & sbit_s}};
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = (err_s || req_write) ? RESP : RD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath register updates: request capture, latency counter, response data.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          size_d = req_size;
          sgn_d  = req_signed;
          off_d  = off_s;
          if (err_s || req_write) begin
            rdata_d = '0;
            err_d   = err_s;
          end else begin
            addr_d = aligned_s;
            cnt_d  = 3'(MEM_LAT);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      RD_WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          rdata_d = ld_s;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs; a legal store is strobed combinationally in its accept cycle.
  always_comb begin
    req_ready    = (state_q == IDLE);
    resp_valid   = (state_q == RESP);
    resp_rdata   = rdata_q;
    resp_err     = err_q;
    mem_write_en = store_fire_s;
    if (store_fire_s) begin
      mem_addr    = aligned_s;
      mem_lane_en = st_lane_s;
      mem_data_in = st_data_s;
    end else begin
      mem_addr    = addr_q;
      mem_lane_en = '0;
      mem_data_in = '0;
    end
  end

endmodule
